if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the LoongArch five-stage pipeline: the producer end of the IF→ID interface. It owns the PC, issues requests to a synchronous-read instruction SRAM and presents `{pc, inst}` on `fs_to_ds_bus` under a valid/allow-in handshake. It consumes `br_bus` from ID and redirects fetch, squashing any wrong-path instruction. A one-entry hold buffer keeps the fetched instruction stable while ID stalls.

## Interface
- `RESET_PC`, default 32'h1c000000, address of the first fetched instruction after reset.
- `clk` input 1, single clock, all state on rising edge.
- `rst` input 1, reset, asynchronous, active-high.
- `ds_allow_in` input 1, ID can accept an instruction this cycle.
- `br_bus` input `BR_TO_FS_WD` (33), `{br_taken, br_target[31:0]}`; `br_taken` is already qualified by ID valid.
- `fs_to_ds_valid` output 1, `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus` output `FS_TO_DS_WD` (64), `{fs_pc[31:0], fs_inst[31:0]}`.
- `inst_sram_en` output 1, read request this cycle.
- `inst_sram_we` output 4, always 4'b0.
- `inst_sram_addr` output 32, request address (= `nextpc`).
- `inst_sram_wdata` output 32, always 32'b0.
- `inst_sram_rdata` input 32, read data, valid the cycle after the request.
- `perf_fetch_cnt` output 32, present only with `IF_PERF_CNT_EN`.

## Operation
- Registers: `to_fs_valid` (pre-IF live), `fs_valid`, `fs_pc`, `inst_buf[31:0]`, `buf_valid`.
- `fs_ready_go` = 1. `fs_allow_in` = `!fs_valid || ds_allow_in || br_taken`.
- `seq_pc` = `fs_pc + 4` (32-bit, wraps mod 2^32). `nextpc` = `br_taken ? br_target : seq_pc`.
- `inst_sram_en` = `to_fs_valid && fs_allow_in`; `inst_sram_addr` = `nextpc`.
- On edge with `inst_sram_en`: `fs_pc <= nextpc`, `fs_valid <= 1`, `buf_valid <= 0`.
- `fs_inst` = `buf_valid ? inst_buf : inst_sram_rdata`.
- `fs_to_ds_valid` = `fs_valid && !br_taken` (wrong-path entry squashed the cycle ID redirects).
- Hold buffer: `fs_valid && !buf_valid && !fs_allow_in` → `inst_buf <= inst_sram_rdata`, `buf_valid <= 1`. Buffer held until next accepted request.
- Redirect: `br_taken` always wins over stall; fetch from `br_target` issues the same cycle; buffer discarded.
- `br_taken` held N cycles (ID stalled): `br_target` refetched every cycle, `fs_to_ds_valid` stays 0; first cycle after release presents the target instruction.
- Misaligned `br_target` is passed through unchanged (no check).

## Timing
- Reset values: `to_fs_valid`=0, `fs_valid`=0, `fs_pc`=`RESET_PC`-4, `buf_valid`=0, `inst_buf`=0; hence `fs_to_ds_valid`=0, `inst_sram_en`=0, `inst_sram_addr`=`RESET_PC`, `we`/`wdata`=0, `perf_fetch_cnt`=0.
- First edge after reset release: `to_fs_valid`=1; request `RESET_PC` issued that cycle; next cycle `fs_to_ds_valid`=1 with `{RESET_PC, mem[RESET_PC]}`.
- Steady state: one instruction per cycle, request-to-present latency 1 cycle.
- Transfer to ID occurs on edge where `fs_to_ds_valid && ds_allow_in`.
- Taken branch: exactly one bubble (squashed slot) between branch in ID and target in IF.
- Reset asserted mid-stall or mid-redirect: all state cleared immediately, buffered instruction lost, restart at `RESET_PC`.

## Configuration
- `IF_PERF_CNT_EN` defined: `perf_fetch_cnt` port and 32-bit counter exist; increments by 1 on each edge with `fs_to_ds_valid && ds_allow_in`, wraps at 2^32, async-cleared by `rst`.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, `ds_allow_in`=1, mem[i]=i: bus shows `{1c000000,..}`, `{1c000004,..}`, `{1c000008,..}` on consecutive cycles.
- Hold `ds_allow_in`=0 for 3 cycles at pc 1c000004 while SRAM rdata changes: bus stays `{1c000004, mem[1c000004]}`, `inst_sram_en`=0, resumes with 1c000008.
- `br_taken`=1, target 1c000100, one cycle: `fs_to_ds_valid`=0 that cycle, next cycle `{1c000100, mem[1c000100]}`.
- `br_taken` held 3 cycles with `ds_allow_in`=0: `inst_sram_addr`=1c000100 each cycle, no valid output; target presented after release, buffer not used.
- Assert `rst` during stall with `buf_valid`=1: outputs to reset values asynchronously; after release fetch restarts at 1c000000.
- With `IF_PERF_CNT_EN`: 10 transfers with 2 stalls and 1 squash → `perf_fetch_cnt`=10.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// IF -> ID handshake bundle: fetched {pc, inst} under valid/allow-in, plus the
// branch redirect travelling back from ID.
interface if_fetch_stage_if;
    localparam int BR_TO_FS_WD = 33;
    localparam int FS_TO_DS_WD = 64;

    logic                   ds_allow_in;
    logic [BR_TO_FS_WD-1:0] br_bus;        // {br_taken, br_target[31:0]}
    logic                   fs_to_ds_valid;
    logic [FS_TO_DS_WD-1:0] fs_to_ds_bus;  // {fs_pc[31:0], fs_inst[31:0]}

    // Fetch stage drives the instruction, ID drives allow-in and redirect.
    modport master (
        input  ds_allow_in,
        input  br_bus,
        output fs_to_ds_valid,
        output fs_to_ds_bus
    );

    modport slave (
        output ds_allow_in,
        output br_bus,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus
    );
endinterface

// File: rtl/if_fetch_stage.sv
// LoongArch instruction-fetch stage: PC, sync-read SRAM request, one-entry hold
// buffer and branch redirect. Define IF_PERF_CNT_EN to add perf_fetch_cnt.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                    clk,
    input  logic                    rst,
    if_fetch_stage_if.master        fs_ds,
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_we,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata,
    input  logic [31:0]             inst_sram_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch_cnt
`endif
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_ready_go;
    logic        fs_allow_in;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    logic        to_fs_valid_q, to_fs_valid_d;
    logic        fs_valid_q,    fs_valid_d;
    logic [31:0] fs_pc_q,       fs_pc_d;
    logic [31:0] inst_buf_q,    inst_buf_d;
    logic        buf_valid_q,   buf_valid_d;

    assign {br_taken, br_target} = fs_ds.br_bus;

    // A redirect always opens the stage, even while ID is stalled.
    assign fs_ready_go = 1'b1;
    assign fs_allow_in = !fs_valid_q || fs_ds.ds_allow_in || br_taken;
    assign seq_pc      = fs_pc_q + 32'd4;
    assign nextpc      = br_taken ? br_target : seq_pc;

    assign inst_sram_en    = to_fs_valid_q && fs_allow_in;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    // SRAM data is only valid the cycle after the request; the buffer covers stalls.
    assign fs_inst              = buf_valid_q ? inst_buf_q : inst_sram_rdata;
    assign fs_ds.fs_to_ds_valid = fs_valid_q && fs_ready_go && !br_taken;
    assign fs_ds.fs_to_ds_bus   = {fs_pc_q, fs_inst};

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        to_fs_valid_d = 1'b1;
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        inst_buf_d    = inst_buf_q;
        buf_valid_d   = buf_valid_q;

        if (inst_sram_en) begin
            fs_valid_d  = 1'b1;
            fs_pc_d     = nextpc;
            buf_valid_d = 1'b0;
        end else if (fs_valid_q && !buf_valid_q && !fs_allow_in) begin
            inst_buf_d  = inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_fs_valid_q <= 1'b0;
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - 32'd4;
            inst_buf_q    <= 32'b0;
            buf_valid_q   <= 1'b0;
        end else begin
            to_fs_valid_q <= to_fs_valid_d;
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            inst_buf_q    <= inst_buf_d;
            buf_valid_q   <= buf_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (fs_ds.fs_to_ds_valid && fs_ds.ds_allow_in) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= 32'b0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed stall/branch/reset sequences,
// expected {pc, inst} queued up front and checked by an independent monitor.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] junk = 32'd0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_stage_if fs_ds ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .fs_ds           (fs_ds),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    // Sync-read SRAM; with no request the read port shows garbage so a missing
    // hold buffer is exposed.
    always @(posedge clk) begin
        junk            <= junk + 32'd1;
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : (32'hbad0_0000 | junk);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic check_reset_outputs;
        check("rst_valid", 64'(fs_ds.fs_to_ds_valid), 64'd0);
        check("rst_en",    64'(inst_sram_en),         64'd0);
        check("rst_addr",  64'(inst_sram_addr),       64'(RESET_PC));
        check("rst_we",    64'(inst_sram_we),         64'd0);
        check("rst_wdata", 64'(inst_sram_wdata),      64'd0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf",  64'(perf_fetch_cnt),       64'd0);
`endif
    endtask

    // Monitor: compares whatever is presented against the queue head and pops
    // only when ID accepts it, so a stalled entry is rechecked every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && fs_ds.fs_to_ds_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", fs_ds.fs_to_ds_bus);
                end else begin
                    check("fs_to_ds_bus", fs_ds.fs_to_ds_bus, exp_q[0]);
                    if (fs_ds.ds_allow_in) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fs_ds.ds_allow_in = 1'b1;
        fs_ds.br_bus      = 33'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();

        // Sequential fetch from reset, then a 3-cycle stall on 1c000004.
        push(32'h1c000000);
        push(32'h1c000004);
        rst = 1'b0;
        tick();
        check("first_en",   64'(inst_sram_en),   64'd1);
        check("first_addr", 64'(inst_sram_addr), 64'h1c000000);
        tick();
        tick();
        fs_ds.ds_allow_in = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_en",   64'(inst_sram_en),   64'd0);
            check("stall_addr", 64'(inst_sram_addr), 64'h1c000008);
            tick();
        end
        fs_ds.ds_allow_in = 1'b1;
        tick();

        // Single-cycle redirect squashes 1c000008.
        fs_ds.br_bus = {1'b1, 32'h1c000100};
        #1;
        check("br_squash", 64'(fs_ds.fs_to_ds_valid), 64'd0);
        check("br_en",     64'(inst_sram_en),         64'd1);
        check("br_addr",   64'(inst_sram_addr),       64'h1c000100);
        push(32'h1c000100);
        push(32'h1c000104);
        tick();
        fs_ds.br_bus = 33'b0;
        tick();
        tick();

        // Redirect held 3 cycles while ID is stalled.
        fs_ds.br_bus      = {1'b1, 32'h1c000200};
        fs_ds.ds_allow_in = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("brh_valid", 64'(fs_ds.fs_to_ds_valid), 64'd0);
            check("brh_en",    64'(inst_sram_en),         64'd1);
            check("brh_addr",  64'(inst_sram_addr),       64'h1c000200);
            tick();
        end
        push(32'h1c000200);
        push(32'h1c000204);
        push(32'h1c000208);
        fs_ds.br_bus      = 33'b0;
        fs_ds.ds_allow_in = 1'b1;
        tick();
        tick();

        // Stall on 1c000208 until the buffer is in use, then reset mid-stall.
        fs_ds.ds_allow_in = 1'b0;
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        tick();
        check_reset_outputs();

        // Restart: 10 transfers with 2 stalls and one squash.
        fs_ds.ds_allow_in = 1'b1;
        foreach (exp_q[i]) ;
        push(32'h1c000000);
        push(32'h1c000004);
        push(32'h1c000008);
        push(32'h1c00000c);
        push(32'h1c000010);
        push(32'h1c000014);
        push(32'h1c000300);
        push(32'h1c000304);
        push(32'h1c000308);
        push(32'h1c00030c);
        push(32'h1c000310);
        rst = 1'b0;
        tick();
        check("restart_addr", 64'(inst_sram_addr), 64'h1c000000);
        tick();
        tick();
        tick();
        fs_ds.ds_allow_in = 1'b0;
        tick();
        fs_ds.ds_allow_in = 1'b1;
        tick();
        tick();
        fs_ds.ds_allow_in = 1'b0;
        tick();
        fs_ds.ds_allow_in = 1'b1;
        tick();
        tick();
        fs_ds.br_bus = {1'b1, 32'h1c000300};
        #1;
        check("br2_squash", 64'(fs_ds.fs_to_ds_valid), 64'd0);
        tick();
        fs_ds.br_bus = 33'b0;
        repeat (4) tick();
        fs_ds.ds_allow_in = 1'b0;
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'd10);
`endif
        tick();
        @(negedge clk);
        #1;
        check("queue_left", 64'(exp_q.size()), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
